// File: rtl/score4_game_ctrl.sv
// Score 4 (7x6 connect-four) sequencing controller: board, turn, cursor, drop and end-of-game FSM.
// Optional per-turn move timeout is compiled in with `define SCORE4_MOVE_TIMEOUT_EN.
module score4_game_ctrl #(
    parameter int COLS           = 7,
    parameter int ROWS           = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            left,
    input  logic                            right,
    input  logic                            put,
    input  logic                            win_exists,
    input  logic                            win_player,
    output logic [COLS-1:0][ROWS-1:0][1:0]  panel,
    output logic                            turn,
    output logic [$clog2(COLS)-1:0]         cursor,
    output logic                            game_over,
    output logic                            winner,
    output logic                            draw,
    output logic                            illegal,
    output logic                            timeout
);
    localparam int CW = $clog2(COLS);
    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(COLS * ROWS + 1);
    localparam logic [CW-1:0] CUR_HOME  = CW'(COLS / 2);
    localparam logic [CW-1:0] CUR_MAX   = CW'(COLS - 1);
    localparam logic [HW-1:0] H_FULL    = HW'(ROWS);
    localparam logic [MW-1:0] MOVES_ALL = MW'(COLS * ROWS);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_WON, S_DRAW} state_t;

    state_t                         state_q, state_d;
    logic [COLS-1:0][ROWS-1:0][1:0] panel_q, panel_d;
    logic [COLS-1:0][HW-1:0]        heights_q, heights_d;
    logic [MW-1:0]                  move_cnt_q, move_cnt_d;
    logic [CW-1:0]                  cursor_q, cursor_d;
    logic turn_q, turn_d, game_over_q, game_over_d, winner_q, winner_d;
    logic draw_q, draw_d, illegal_q, illegal_d, timeout_q, timeout_d;
    logic col_full;
    logic expire;

    assign col_full = (heights_q[cursor_q] == H_FULL);

`ifdef SCORE4_MOVE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] turn_cnt_q, turn_cnt_d;

    // A put at the last count defers the timeout: the counter holds until a put-free cycle.
    assign expire = (state_q == S_PLAY) && !put && (turn_cnt_q == T_LAST);

    always_comb begin
        turn_cnt_d = '0;
        if (state_q == S_PLAY && !expire)
            turn_cnt_d = (turn_cnt_q == T_LAST) ? turn_cnt_q : turn_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) turn_cnt_q <= '0;
        else     turn_cnt_q <= turn_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign expire             = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d starts from a hold/default value so no path leaves it unassigned (no latch).
        state_d     = state_q;
        panel_d     = panel_q;
        heights_d   = heights_q;
        move_cnt_d  = move_cnt_q;
        cursor_d    = cursor_q;
        turn_d      = turn_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        draw_d      = draw_q;
        illegal_d   = 1'b0;
        timeout_d   = expire;
        unique case (state_q)
            S_IDLE, S_WON, S_DRAW: begin
                if (start) begin
                    panel_d     = '0;
                    heights_d   = '0;
                    move_cnt_d  = '0;
                    cursor_d    = CUR_HOME;
                    turn_d      = 1'b0;
                    game_over_d = 1'b0;
                    winner_d    = 1'b0;
                    draw_d      = 1'b0;
                    state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (put) begin
                    if (col_full) begin
                        illegal_d = 1'b1;
                    end else begin
                        panel_d[cursor_q][heights_q[cursor_q]] = turn_q ? 2'b10 : 2'b01;
                        heights_d[cursor_q] = heights_q[cursor_q] + 1'b1;
                        move_cnt_d          = move_cnt_q + 1'b1;
                        turn_d              = ~turn_q;
                        state_d             = S_CHECK;
                    end
                end else begin
                    if (expire) turn_d = ~turn_q;
                    if (left && !right)
                        cursor_d = (cursor_q == '0) ? CUR_MAX : cursor_q - 1'b1;
                    else if (right && !left)
                        cursor_d = (cursor_q == CUR_MAX) ? '0 : cursor_q + 1'b1;
                end
            end
            S_CHECK: begin
                // The detector looks at the board just updated; a 4-in-line beats a full board.
                if (win_exists) begin
                    state_d     = S_WON;
                    game_over_d = 1'b1;
                    winner_d    = win_player;
                end else if (move_cnt_q == MOVES_ALL) begin
                    state_d     = S_DRAW;
                    game_over_d = 1'b1;
                    draw_d      = 1'b1;
                end else begin
                    state_d     = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the board array is reset explicitly; it is flop storage read every cycle, not a RAM.
            state_q     <= S_IDLE;
            panel_q     <= '0;
            heights_q   <= '0;
            move_cnt_q  <= '0;
            cursor_q    <= CUR_HOME;
            turn_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            panel_q     <= panel_d;
            heights_q   <= heights_d;
            move_cnt_q  <= move_cnt_d;
            cursor_q    <= cursor_d;
            turn_q      <= turn_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            draw_q      <= draw_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
        end
    end

    assign panel     = panel_q;
    assign turn      = turn_q;
    assign cursor    = cursor_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign draw      = draw_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule
